// File: rtl/cnn_bram_reader_pkg.sv
// Shared image-size constants, default CNN geometry and reader FSM encoding.
// Imported by the BRAM reader and the downstream combine/core stages.
package cnn_bram_reader_pkg;

  localparam int DEF_I_F_BW = 8;
  localparam int DEF_W_BW   = 8;
  localparam int DEF_B_BW   = 16;
  localparam int DEF_CI     = 1;
  localparam int DEF_CO     = 2;
  localparam int DEF_KX     = 3;
  localparam int DEF_KY     = 3;

  localparam int FMAP_BITS = DEF_CI * DEF_KX * DEF_KY * DEF_I_F_BW;
  localparam int WGT_BITS  = DEF_CO * DEF_CI * DEF_KX * DEF_KY * DEF_W_BW;
  localparam int BIAS_BITS = DEF_CO * DEF_B_BW;
  localparam int NUM_WORDS = 1 + (FMAP_BITS + WGT_BITS + BIAS_BITS) / DEF_I_F_BW;

  // state | meaning
  // IDLE  | waiting for start, all outputs 0
  // READ  | issuing one BRAM read per cycle
  // DRAIN | waiting RD_LAT cycles for the last word to return
  // DONE  | image complete, operands held until next start
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  function automatic int calc_num_words(input int hdr, input int ci, input int co,
                                        input int kx, input int ky, input int ifbw,
                                        input int wbw, input int bbw);
    return hdr + (ci*kx*ky*ifbw + co*ci*kx*ky*wbw + co*bbw) / ifbw;
  endfunction

endpackage

// File: rtl/cnn_rd_lat_pipe.sv
// Valid/last shift register matching the BRAM read latency, so the reader
// knows which returning rdata cycle carries the final word of the image.
module cnn_rd_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_last  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_last;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_last[k]  <= r_last[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_last  = r_last[DEPTH-1];

endmodule

// File: rtl/cnn_bram_reader.sv
// Streams one packed parameter image (header + fmap + weights + bias) out of a
// byte-wide BRAM into the combine stage, then holds done until the next start.
module cnn_bram_reader
  import cnn_bram_reader_pkg::*;
#(
  parameter int I_F_BW    = DEF_I_F_BW,
  parameter int W_BW      = DEF_W_BW,
  parameter int B_BW      = DEF_B_BW,
  parameter int CI        = DEF_CI,
  parameter int CO        = DEF_CO,
  parameter int KX        = DEF_KX,
  parameter int KY        = DEF_KY,
  parameter int HDR_WORDS = 1,
  parameter int RD_LAT    = 1,
  parameter int MEM_AW    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] base_addr,
  output logic              busy,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [I_F_BW-1:0] mem_rdata,
  output logic [I_F_BW-1:0] out_fmap,
  output logic [31:0]       out_f_address,
  output logic              out_f_enable,
  output logic              out_f_value_done,
  output logic              out_f_done
);

  localparam int NWORDS = calc_num_words(HDR_WORDS, CI, CO, KX, KY, I_F_BW, W_BW, B_BW);
  localparam int IW     = $clog2(NWORDS) + 1;
  localparam int DW     = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NWORDS - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(RD_LAT);

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic [MEM_AW-1:0] r_base;
  logic [IW-1:0]     r_idx;
  logic [DW-1:0]     r_drain;
  logic              r_mem_en;
  logic              r_last_issue;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [IW-1:0]     r_f_addr;
  logic [I_F_BW-1:0] r_fmap;
  logic              r_vdone;

  logic w_start_acc;
  logic w_issue_last;
  logic w_pipe_valid;
  logic w_pipe_last;

  // start is only honoured when not busy; a start while READ/DRAIN is dropped
  assign w_start_acc  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_issue_last = (r_state == ST_READ) && (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_READ;
      ST_READ:  if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_drain == '0) w_state_nxt = ST_DONE;
      ST_DONE:  if (start) w_state_nxt = ST_READ;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base       <= '0;
      r_idx        <= '0;
      r_drain      <= '0;
      r_mem_en     <= 1'b0;
      r_last_issue <= 1'b0;
      r_mem_addr   <= '0;
      r_f_addr     <= '0;
      r_fmap       <= '0;
      r_vdone      <= 1'b0;
    end else begin
      r_mem_en     <= (r_state == ST_READ);
      r_last_issue <= w_issue_last;

      if (w_start_acc) begin
        r_base <= base_addr;
        r_idx  <= '0;
      end else if (r_state == ST_READ) begin
        r_idx <= r_idx + IW'(1);
      end

      if (r_state == ST_READ) begin
        r_mem_addr <= r_base + MEM_AW'(r_idx);
        r_f_addr   <= r_idx;
      end

      if (w_issue_last)
        r_drain <= DRAIN_INIT;
      else if ((r_state == ST_DRAIN) && (r_drain != '0))
        r_drain <= r_drain - DW'(1);

      // out_fmap freezes in DONE so the core sees the last word
      if ((r_state == ST_READ) || (r_state == ST_DRAIN))
        r_fmap <= mem_rdata;

      if (w_start_acc)
        r_vdone <= 1'b0;
      else if (w_pipe_valid && w_pipe_last)
        r_vdone <= 1'b1;
    end
  end

  cnn_rd_lat_pipe #(
    .DEPTH (RD_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (r_mem_en),
    .i_last  (r_last_issue),
    .o_valid (w_pipe_valid),
    .o_last  (w_pipe_last)
  );

  assign busy             = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign mem_en           = r_mem_en;
  assign mem_addr         = r_mem_addr;
  assign out_fmap         = r_fmap;
  assign out_f_address    = 32'(r_f_addr);
  assign out_f_enable     = (r_state != ST_IDLE);
  assign out_f_value_done = r_vdone;
  assign out_f_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_cnn_bram_reader.sv
// Directed bench for cnn_bram_reader: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a simple BRAM model whose word at address a is a[7:0]^{a[11:8],a[11:8]}.
module tb_cnn_bram_reader;

  localparam int NW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start, start_3;
  logic [AW-1:0] base_addr, base_addr_3;

  logic          busy, mem_en, out_f_enable, out_f_value_done, out_f_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = '0;
  logic [7:0]    out_fmap;
  logic [31:0]   out_f_address;

  logic          busy_3, mem_en_3, out_f_enable_3, out_f_value_done_3, out_f_done_3;
  logic [AW-1:0] mem_addr_3;
  logic [7:0]    mem_rdata_3 = '0;
  logic [7:0]    out_fmap_3;
  logic [31:0]   out_f_address_3;

  cnn_bram_reader #(.RD_LAT(1)) dut (
    .clk (clk), .reset (reset), .start (start), .base_addr (base_addr),
    .busy (busy), .mem_en (mem_en), .mem_addr (mem_addr), .mem_rdata (mem_rdata),
    .out_fmap (out_fmap), .out_f_address (out_f_address), .out_f_enable (out_f_enable),
    .out_f_value_done (out_f_value_done), .out_f_done (out_f_done)
  );

  cnn_bram_reader #(.RD_LAT(3)) dut3 (
    .clk (clk), .reset (reset), .start (start_3), .base_addr (base_addr_3),
    .busy (busy_3), .mem_en (mem_en_3), .mem_addr (mem_addr_3), .mem_rdata (mem_rdata_3),
    .out_fmap (out_fmap_3), .out_f_address (out_f_address_3), .out_f_enable (out_f_enable_3),
    .out_f_value_done (out_f_value_done_3), .out_f_done (out_f_done_3)
  );

  function automatic logic [7:0] fdat(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  // BRAM models: data valid 1 resp. 3 cycles after the enabled address
  always @(posedge clk) if (mem_en) mem_rdata <= fdat(mem_addr);

  logic [7:0] q0 = '0, q1 = '0;
  always @(posedge clk) begin
    if (mem_en_3) q0 <= fdat(mem_addr_3);
    q1          <= q0;
    mem_rdata_3 <= q1;
  end

  logic          sel;
  logic          s_busy, s_en, s_ena, s_vdone, s_done;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_fmap;
  logic [31:0]   s_faddr;

  always_comb begin
    s_busy  = sel ? busy_3             : busy;
    s_en    = sel ? mem_en_3           : mem_en;
    s_ena   = sel ? out_f_enable_3     : out_f_enable;
    s_vdone = sel ? out_f_value_done_3 : out_f_value_done;
    s_done  = sel ? out_f_done_3       : out_f_done;
    s_addr  = sel ? mem_addr_3         : mem_addr;
    s_fmap  = sel ? out_fmap_3         : out_fmap;
    s_faddr = sel ? out_f_address_3    : out_f_address;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic drive_start(input bit s3, input logic v, input logic [AW-1:0] b);
    if (s3) begin
      start_3 = v;
      if (v) base_addr_3 = b;
    end else begin
      start = v;
      if (v) base_addr = b;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},   32'(s_busy),  32'd0);
    chk({tag, " mem_en"}, 32'(s_en),    32'd0);
    chk({tag, " addr"},   32'(s_addr),  32'd0);
    chk({tag, " fmap"},   32'(s_fmap),  32'd0);
    chk({tag, " faddr"},  s_faddr,      32'd0);
    chk({tag, " enable"}, 32'(s_ena),   32'd0);
    chk({tag, " vdone"},  32'(s_vdone), 32'd0);
    chk({tag, " done"},   32'(s_done),  32'd0);
  endtask

  // Pulse start, then compare every output against the timing model each cycle.
  // Cycle c is sampled at the negedge following the c-th edge after the start edge.
  task automatic run_fetch(input bit s3, input logic [AW-1:0] base, input int intr_c,
                           input logic [AW-1:0] intr_base, output int done_c,
                           output logic [AW-1:0] last_addr, output logic [7:0] last_fmap);
    int            lat;
    int            k;
    logic [AW-1:0] a;
    string         t;
    lat    = s3 ? 3 : 1;
    done_c = -1;
    sel    = s3;
    @(negedge clk);
    drive_start(s3, 1'b1, base);
    for (int c = 0; c <= NW + lat + 4; c++) begin
      @(negedge clk);
      drive_start(s3, (c == intr_c), intr_base);
      t = $sformatf("L%0d base=%0h c=%0d", lat, base, c);
      chk({t, " busy"},   32'(s_busy), 32'(c <= NW + lat));
      chk({t, " enable"}, 32'(s_ena),  32'd1);
      chk({t, " mem_en"}, 32'(s_en),   32'((c >= 1) && (c <= NW)));
      if (c >= 1) begin
        k = (c - 1 < NW - 1) ? c - 1 : NW - 1;
        a = base + AW'(k);
        chk({t, " addr"},  32'(s_addr), 32'(a));
        chk({t, " faddr"}, s_faddr,     32'(k));
      end
      if (c >= lat + 2) begin
        k = (c - lat - 2 < NW - 1) ? c - lat - 2 : NW - 1;
        a = base + AW'(k);
        chk({t, " fmap"}, 32'(s_fmap), 32'(fdat(a)));
      end
      chk({t, " done"},  32'(s_done),  32'(c >= NW + lat + 1));
      chk({t, " vdone"}, 32'(s_vdone), 32'(c >= NW + lat + 1));
      if (s_done && done_c < 0) done_c = c;
    end
    drive_start(s3, 1'b0, '0);
    last_addr = s_addr;
    last_fmap = s_fmap;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    bit            s3;
    int            intr_c;
    logic [AW-1:0] intr_base;
    int            exp_done_c;
    logic [AW-1:0] exp_last_addr;
    logic [7:0]    exp_last_fmap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int            dc;
    logic [AW-1:0] la;
    logic [7:0]    lf;
    bit            in_done[2];
    logic [7:0]    held[2];

    vecs[0] = '{12'h000, 1'b0, -1, 12'h000, 34, 12'h01F, 8'h1F};  // basic
    vecs[1] = '{12'h100, 1'b0, -1, 12'h000, 34, 12'h11F, 8'h0E};  // restart from DONE
    vecs[2] = '{12'hFF0, 1'b0, -1, 12'h000, 34, 12'h00F, 8'h0F};  // address wrap
    vecs[3] = '{12'h200, 1'b0, 10, 12'h300, 34, 12'h21F, 8'h3D};  // start ignored while busy
    vecs[4] = '{12'h000, 1'b1, -1, 12'h000, 36, 12'h01F, 8'h1F};  // RD_LAT=3

    in_done[0] = 1'b0; in_done[1] = 1'b0;
    held[0] = '0; held[1] = '0;
    reset = 1'b1; start = 1'b0; start_3 = 1'b0; base_addr = '0; base_addr_3 = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1 chk_idle("reset L1");
    sel = 1'b1; #1 chk_idle("reset L3");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      sel = vecs[i].s3;
      if (in_done[vecs[i].s3]) begin
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          chk($sformatf("hold%0d done", h),   32'(s_done),  32'd1);
          chk($sformatf("hold%0d vdone", h),  32'(s_vdone), 32'd1);
          chk($sformatf("hold%0d busy", h),   32'(s_busy),  32'd0);
          chk($sformatf("hold%0d mem_en", h), 32'(s_en),    32'd0);
          chk($sformatf("hold%0d fmap", h),   32'(s_fmap),  32'(held[vecs[i].s3]));
        end
      end
      run_fetch(vecs[i].s3, vecs[i].base, vecs[i].intr_c, vecs[i].intr_base, dc, la, lf);
      chk($sformatf("vec%0d done cycle", i), 32'(dc), 32'(vecs[i].exp_done_c));
      chk($sformatf("vec%0d last addr", i),  32'(la), 32'(vecs[i].exp_last_addr));
      chk($sformatf("vec%0d last fmap", i),  32'(lf), 32'(vecs[i].exp_last_fmap));
      in_done[vecs[i].s3] = 1'b1;
      held[vecs[i].s3]    = vecs[i].exp_last_fmap;
    end

    // reset while the word at idx 12 is being issued
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 12'h000;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 13; c++) @(negedge clk);
    chk("midreset pre addr",  32'(mem_addr), 32'h00C);
    chk("midreset pre faddr", out_f_address, 32'd12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("midreset");
    repeat (RD_LAT_WAIT()) @(negedge clk);
    chk_idle("midreset settle");

    // reset and start in the same cycle: reset wins
    start = 1'b1; reset = 1'b1; base_addr = 12'h040;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk_idle("reset+start");
    @(negedge clk);
    chk_idle("reset+start next");

    run_fetch(1'b0, 12'h040, -1, 12'h000, dc, la, lf);
    chk("post-reset done cycle", 32'(dc), 32'd34);
    chk("post-reset last addr",  32'(la), 32'h05F);
    chk("post-reset last fmap",  32'(lf), 32'h5F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  function automatic int RD_LAT_WAIT();
    return 4;
  endfunction

endmodule
